// File: rtl/acc_axis_pkg.sv
// -----------------------------------------------------------------------------
// acc_axis_pkg
//
// Types and defaults shared by the step-sum accumulator and the
// lane serializer that sits after it on the AXI-Stream path.
//
//   DEF_LANES   : default number of lanes in one accumulator result beat
//   DEF_DATA_W  : default width of one lane
//   lane_vec_t  : one multi-lane result beat at the default geometry,
//                 lane 0 in the least significant slot
//   ser_state_e : serializer control states
// -----------------------------------------------------------------------------
package acc_axis_pkg;

    localparam int DEF_LANES  = 2;
    localparam int DEF_DATA_W = 7;

    typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] lane_vec_t;

    // IDLE : no beat held, input side is open
    // SEND : a held beat is being replayed one lane at a time
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage : acc_axis_pkg

// File: rtl/acc_lane_serializer.sv
// -----------------------------------------------------------------------------
// acc_lane_serializer
//
// Accepts one LANES x DATA_W result beat per input handshake and replays it
// as LANES single-lane beats on a narrow AXI-Stream master, lane 0 first.
// Packet framing is carried through on the last lane of a beat, and every
// accepted output beat that closes a packet bumps a wrapping packet counter.
// With m_ready held high the output streams one lane per cycle, and a new
// input beat can be taken in the same cycle the last lane leaves, so
// back-to-back input beats produce an unbroken m_valid stream.
//
// Ports
//   clk      : single clock, all state on the rising edge
//   rstn     : asynchronous active-low reset
//   s_valid  : input beat valid
//   s_ready  : input beat ready (0 while rstn is low)
//   s_data   : LANES result lanes, lane 0 in the low slot
//   s_last   : input beat ends a packet
//   m_valid  : output lane valid
//   m_ready  : output lane ready
//   m_data   : current lane value (bit-exact copy of the input lane)
//   m_lane   : index of the lane currently on m_data
//   m_last   : set only on lane LANES-1 of a beat that carried s_last
//   pkt_cnt  : number of accepted output beats with m_last, wraps
// -----------------------------------------------------------------------------
module acc_lane_serializer
    import acc_axis_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [LANES-1:0][DATA_W-1:0]  s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [$clog2(LANES)-1:0]      m_lane,
    output logic                          m_last,
    output logic [CNT_W-1:0]              pkt_cnt
);

    localparam int                LANE_W    = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ser_state_e                  state_q,     state_d;
    logic [LANE_W-1:0]           lane_q,      lane_d;
    logic [LANES-1:0][DATA_W-1:0] hold_data_q, hold_data_d;
    logic                        hold_last_q, hold_last_d;
    logic [CNT_W-1:0]            pkt_cnt_q,   pkt_cnt_d;

    // Ready to take a new beat, before the reset gate is applied.
    logic take_ok;
    logic on_last_lane;
    logic out_fire;

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        pkt_cnt_d   = pkt_cnt_q;

        m_valid     = 1'b0;
        m_data      = '0;
        m_lane      = '0;
        m_last      = 1'b0;
        take_ok     = 1'b0;

        on_last_lane = (lane_q == LAST_LANE);

        unique case (state_q)
            IDLE: begin
                take_ok = 1'b1;
                if (s_valid) begin
                    hold_data_d = s_data;
                    hold_last_d = s_last;
                    lane_d      = '0;
                    state_d     = SEND;
                end
            end

            SEND: begin
                m_valid = 1'b1;
                m_data  = hold_data_q[lane_q];
                m_lane  = lane_q;
                m_last  = hold_last_q && on_last_lane;

                if (m_ready) begin
                    if (!on_last_lane) begin
                        lane_d = lane_q + LANE_W'(1);
                    end else begin
                        // The last lane is leaving this cycle, so the holding
                        // register is free to take the next beat right now.
                        take_ok = 1'b1;
                        if (s_valid) begin
                            hold_data_d = s_data;
                            hold_last_d = s_last;
                            lane_d      = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_fire = m_valid && m_ready && m_last;
        if (out_fire) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    // s_ready never looks at s_valid; the rstn term keeps the input side
    // closed for the whole time reset is held, not just until the next edge.
    assign s_ready = rstn && take_ok;
    assign pkt_cnt = pkt_cnt_q;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

endmodule : acc_lane_serializer

// File: tb/tb_acc_lane_serializer.sv
module tb_acc_lane_serializer;
    import acc_axis_pkg::*;

    localparam int LANES  = 2;
    localparam int DATA_W = 7;

    logic                 clk;
    logic                 rstn;
    logic                 s_valid;
    lane_vec_t            s_data;
    logic                 s_last;
    logic                 m_ready;

    logic                 s_ready,   s_ready_w;
    logic                 m_valid,   m_valid_w;
    logic [DATA_W-1:0]    m_data,    m_data_w;
    logic [0:0]           m_lane,    m_lane_w;
    logic                 m_last,    m_last_w;
    logic [15:0]          pkt_cnt;
    logic [1:0]           pkt_cnt_w;

    acc_lane_serializer #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane),
        .m_last(m_last), .pkt_cnt(pkt_cnt)
    );

    // Narrow-counter copy on the same stream, used for the wrap behaviour.
    acc_lane_serializer #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(2)) dut_w (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w), .m_lane(m_lane_w),
        .m_last(m_last_w), .pkt_cnt(pkt_cnt_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Every accepted input beat becomes LANES queued output lanes; the queue
    // front is what the output must show, and the input may only be taken
    // when the queue is empty or its single remaining lane leaves now.
    typedef struct {
        logic [DATA_W-1:0] d;
        logic [0:0]        lane;
        logic              last;
    } ent_t;

    ent_t        q[$];
    int          out_log[$];
    int          last_log[$];
    logic [15:0] exp_cnt;
    bit          mon_en;
    bit          exp_rdy, exp_vld;
    bit          stall_prev;
    logic [8:0]  stall_val;
    int          cyc, vcnt, vfirst, vlast;
    int          mr_mode;

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            ent_t e;
            cyc++;
            exp_vld = (q.size() != 0);
            exp_rdy = (q.size() == 0) || (q.size() == 1 && m_ready);
            chk("s_ready", s_ready, exp_rdy);
            chk("m_valid", m_valid, exp_vld);
            chk("pkt_cnt", pkt_cnt, exp_cnt);
            chk("w_pkt_cnt", pkt_cnt_w, exp_cnt[1:0]);
            chk("w_ctl", {m_valid_w, s_ready_w}, {exp_vld, exp_rdy});
            if (stall_prev) chk("stall_hold", {m_data, m_lane, m_last}, stall_val);
            stall_prev = 1'b0;
            if (exp_vld) begin
                chk("m_data", m_data, q[0].d);
                chk("m_lane", m_lane, q[0].lane);
                chk("m_last", m_last, q[0].last);
                chk("w_beat", {m_data_w, m_lane_w, m_last_w}, {q[0].d, q[0].lane, q[0].last});
                vcnt++;
                if (vfirst < 0) vfirst = cyc;
                vlast = cyc;
                if (!m_ready) begin
                    stall_prev = 1'b1;
                    stall_val  = {q[0].d, q[0].lane, q[0].last};
                end
            end
            if (exp_vld && m_ready) begin
                e = q.pop_front();
                out_log.push_back(int'(e.d));
                last_log.push_back(int'(e.last));
                if (e.last) exp_cnt++;
            end
            if (s_valid && exp_rdy) begin
                for (int i = 0; i < LANES; i++)
                    q.push_back('{d: s_data[i], lane: 1'(i), last: s_last && (i == LANES - 1)});
            end
        end
    end

    // m_ready driver: 0 = always ready, 1 = toggle, 2 = random
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------------------------------------------------------- tasks
    // Present a beat and hold it until taken; returns just after the accepting
    // edge with s_valid still high so the caller can chain beats without a gap.
    task automatic send_beat(input lane_vec_t d, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 1, 0);
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 1, 0);
        @(negedge clk);
        #1;
    endtask

    // Called just after a rising edge; drops reset between edges.
    task automatic apply_reset();
        #2;
        mon_en  = 1'b0;
        s_valid = 1'b0;
        rstn    = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_m_lane",  m_lane,  0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_w",       {m_valid_w, s_ready_w, m_last_w, pkt_cnt_w}, 0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        q.delete();
        exp_cnt    = '0;
        stall_prev = 1'b0;
        #1;
        chk("rel_s_ready", s_ready, 1);
        mon_en = 1'b1;
    endtask

    task automatic clear_logs();
        out_log.delete();
        last_log.delete();
        vcnt   = 0;
        vfirst = -1;
        vlast  = -1;
    endtask

    task automatic run_b2b();
        for (int i = 0; i < 4; i++)
            send_beat({7'(i), 7'(i + 1)}, (i == 3));
        drain();
    endtask

    task automatic check_b2b_order(input string tag);
        int exp_seq[8] = '{1, 0, 2, 1, 3, 2, 4, 3};
        int nlast;
        chk({tag, "_len"}, out_log.size(), 8);
        nlast = 0;
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            chk({tag, "_data"}, out_log[i], exp_seq[i]);
            nlast += last_log[i];
        end
        chk({tag, "_nlast"}, nlast, 1);
        if (last_log.size() == 8) chk({tag, "_last8"}, last_log[7], 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int exp_wrap[5] = '{1, 2, 3, 0, 1};
        rstn    = 1'b0;
        mon_en  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        mr_mode = 0;
        exp_cnt = '0;
        cyc     = 0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // single beat {3,5}
        @(posedge clk); #1;
        clear_logs();
        send_beat({7'd3, 7'd5}, 1'b1);
        drain();
        chk("sb_len", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("sb_d0", out_log[0], 5);
            chk("sb_l0", last_log[0], 0);
            chk("sb_d1", out_log[1], 3);
            chk("sb_l1", last_log[1], 1);
        end
        chk("sb_idle", m_valid, 0);
        chk("sb_pkt", pkt_cnt, 1);

        // back-to-back, always ready
        @(posedge clk); #1;
        apply_reset();
        clear_logs();
        run_b2b();
        check_b2b_order("b2b");
        chk("b2b_vcnt", vcnt, 8);
        chk("b2b_span", vlast - vfirst + 1, 8);
        chk("b2b_pkt", pkt_cnt, 1);

        // same stream under toggling back-pressure
        @(posedge clk); #1;
        clear_logs();
        mr_mode = 1;
        run_b2b();
        check_b2b_order("bp");
        chk("bp_pkt", pkt_cnt, 2);
        mr_mode = 0;

        // reset after lane 0 of {6,2} has left
        @(posedge clk); #1;
        apply_reset();
        clear_logs();
        send_beat({7'd6, 7'd2}, 1'b1);
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_lane0", (out_log.size() == 1) ? out_log[0] : -1, 2);
        apply_reset();
        clear_logs();
        repeat (3) @(negedge clk);
        chk("mid_no_lane1", vcnt, 0);
        chk("mid_pkt", pkt_cnt, 0);
        @(posedge clk); #1;
        send_beat({7'd1, 7'd1}, 1'b1);
        drain();
        chk("mid_next_len", out_log.size(), 2);
        if (out_log.size() == 2) chk("mid_next", {out_log[0][6:0], out_log[1][6:0]}, {7'd1, 7'd1});
        chk("mid_next_pkt", pkt_cnt, 1);

        // narrow counter wrap
        @(posedge clk); #1;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            send_beat({7'($urandom), 7'($urandom)}, 1'b1);
            drain();
            chk("wrap", pkt_cnt_w, exp_wrap[k]);
        end

        // random traffic against the model
        @(posedge clk); #1;
        mr_mode = 2;
        for (int b = 0; b < 120; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat({7'($urandom), 7'($urandom)}, 1'($urandom_range(0, 2) == 0));
        end
        drain();
        mr_mode = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule : tb_acc_lane_serializer

// File: doc/acc_lane_serializer.md
# acc_lane_serializer

AXI-Stream stage directly downstream of the step-sum accumulator. It accepts one multi-lane result beat (`LANES` × `DATA_W`, default 2 × 7 bits) per handshake and replays it as `LANES` single-lane beats on a narrow AXI-Stream master, lane 0 first. Packet framing (`tlast`) is carried through, and completed packets are counted. Sustained throughput is one output beat per cycle with no bubbles between input beats.

## Interface
Parameters:
- `LANES`, 2, number of lanes per input beat (≥ 2)
- `DATA_W`, 7, bits per lane
- `CNT_W`, 16, width of the packet counter

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat ready
- `s_data`  in  `[LANES-1:0][DATA_W-1:0]`  result lanes from the accumulator
- `s_last`  in  1  input beat ends a packet
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  output beat ready
- `m_data`  out  `DATA_W`  current lane value
- `m_lane`  out  `$clog2(LANES)`  index of the lane on `m_data`
- `m_last`  out  1  high only on lane `LANES-1` of an input beat that had `s_last`=1
- `pkt_cnt`  out  `CNT_W`  count of output beats accepted with `m_last`=1, wraps modulo 2^`CNT_W`

## Operation
- Holding register: `hold_data`, `hold_last`. Lane counter: `lane`. FSM states: `IDLE`, `SEND`.
- `IDLE`:
  - `s_ready`=1.
  - On `s_valid`: capture `s_data`/`s_last`, set `lane`=0, go to `SEND`.
- `SEND`:
  - `m_valid`=1, `m_data`=`hold_data[lane]`, `m_lane`=`lane`.
  - Hold all outputs stable while `m_ready`=0 (AXIS rule; no retraction).
  - On `m_ready` with `lane`<`LANES-1`: `lane`++.
  - On `m_ready` with `lane`=`LANES-1`, `s_ready` is combinationally 1:
    - if `s_valid`: load the new beat, `lane`=0, stay in `SEND` (back-to-back, no gap);
    - otherwise: go to `IDLE`.
- `s_ready` = `IDLE` OR (`SEND` AND `lane`=`LANES-1` AND `m_ready`). `s_ready` has no dependence on `s_valid`.
- `pkt_cnt` increments on each `m_valid`&`m_ready`&`m_last`.
- No arithmetic on data; lanes pass bit-exact.

## Timing
- Reset (`rstn`=0, asynchronous):
  - state `IDLE`;
  - `m_valid`, `m_last`=0; `m_data`, `m_lane`=0; `pkt_cnt`=0; `hold_*`=0;
  - `s_ready` forced 0 while `rstn` is low; it is 1 from the first cycle after release.
- Latency: input handshake at edge N → `m_valid`=1 with lane 0 after edge N (visible in cycle N+1).
- Throughput: `LANES` output cycles per input beat with `m_ready` held high. Back-to-back input beats produce a continuous `m_valid`=1 stream.
- Back-pressure: `m_ready`=0 on the last lane keeps `s_ready`=0, so no input beat is lost.
- Reset mid-packet: the in-flight beat is discarded, `pkt_cnt` clears, and there is no spurious `m_last`.
- `pkt_cnt` wraps from 2^`CNT_W`−1 to 0.

## Structure
- Shared package `acc_axis_pkg`:
  - `LANES`/`DATA_W` defaults;
  - typedef `lane_vec_t` (`logic [LANES-1:0][DATA_W-1:0]`);
  - enum `ser_state_e` {`IDLE`, `SEND`}.
  The accumulator and this block both use it.
- Single module, no sub-module; the lane select is an indexed read of `hold_data`.

## Test plan
- Reset check: assert `rstn`=0 mid-cycle → all outputs 0 immediately, `s_ready`=0; release → `s_ready`=1 next cycle.
- Single beat: `s_data`={3,5} (lane1=3, lane0=5), `s_last`=1, `m_ready`=1 → `m_data` 5 (`m_lane` 0, `m_last` 0), then 3 (`m_lane` 1, `m_last` 1), then `m_valid`=0; `pkt_cnt`=1.
- Back-to-back beats: 4 beats {i, i+1} for i=0..3, `s_last` on beat 3, `s_valid` always high → 8 consecutive `m_valid` cycles, sequence 1,0,2,1,3,2,4,3, exactly one `m_last` (the 8th), `pkt_cnt`=1.
- Back-pressure: `m_ready` toggled 0/1 every cycle over the previous stream → identical data order, `m_data` stable while stalled, `s_ready` asserted only on accepted last lanes.
- Reset mid-beat: reset after lane 0 of {6,2} accepted → lane 1 never appears, `pkt_cnt`=0; the next beat {1,1} serializes normally.
- Counter wrap (`CNT_W`=2): 5 single-beat packets → `pkt_cnt` reads 1,2,3,0,1.
